// File: rtl/wind_pkg.sv
// wind_pkg: shared types and constants for the wind generator.
//   wind_state_t  - ramp FSM states (IDLE, DRAW, RAMP)
//   LFSR_TAPS16/32 - Galois right-shift feedback masks
//   WIND_*_DEF    - default range / reset values
//   lfsr_taps()   - picks the tap mask for a given LFSR width
package wind_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    RAMP = 2'd2
  } wind_state_t;

  localparam logic [31:0] LFSR_TAPS16   = 32'h0000_B400;
  localparam logic [31:0] LFSR_TAPS32   = 32'h8020_0003;
  localparam int unsigned WIND_MAX_DEF  = 100;
  localparam int unsigned WIND_INIT_DEF = 50;

  function automatic logic [31:0] lfsr_taps(input int unsigned w);
    return (w == 32) ? LFSR_TAPS32 : LFSR_TAPS16;
  endfunction

endpackage

// File: rtl/wind_gen_if.sv
// wind_gen_if: game-control side bundle of the wind generator.
//   next_turn          - level, rising edge requests a new wind draw
//   enter_start_remote - pulse, latches mirrored (remote) view
//   reset_flag         - game restart
//   wind               - current wind, mirrored when latched
//   wind_target        - current target, unmirrored
//   wind_settled       - high when the ramp is idle
// master drives the requests, slave (the generator) drives the wind outputs.
interface wind_gen_if #(
  parameter int unsigned WIND_W = 7
);
  logic              next_turn;
  logic              enter_start_remote;
  logic              reset_flag;
  logic [WIND_W-1:0] wind;
  logic [WIND_W-1:0] wind_target;
  logic              wind_settled;

  modport master (
    output next_turn, enter_start_remote, reset_flag,
    input  wind, wind_target, wind_settled
  );

  modport slave (
    input  next_turn, enter_start_remote, reset_flag,
    output wind, wind_target, wind_settled
  );
endinterface

// File: rtl/wind_gen_lfsr.sv
// wind_lfsr: Galois right-shift LFSR, advances one step per cycle with step high.
//   clk, rst - clock, synchronous active-high reset (loads LFSR_SEED)
//   step     - advance one position
//   value    - current LFSR state
module wind_lfsr import wind_pkg::*; #(
  parameter int unsigned       LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  output logic [LFSR_W-1:0] value
);

  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));

  always_ff @(posedge clk) begin
    if (rst)
      value <= LFSR_SEED;
    else if (step)
      value <= (value >> 1) ^ (value[0] ? TAPS : '0);
  end

endmodule

// File: rtl/wind_gen.sv
// wind_gen: pseudo-random wind source for the game-control layer.
// Each rising edge of next_turn draws a new target in [0, WIND_MAX] from an
// LFSR; the internal wind value then walks toward it by one unit every
// RAMP_DIV cycles. The output can be mirrored (WIND_MAX - value) for the
// remote player's view.
//   clk, rst - clock, synchronous active-high reset
//   bus      - wind_gen_if.slave: next_turn, enter_start_remote, reset_flag in;
//              wind, wind_target, wind_settled out (all registered)
// Optional build macro WIND_GUST_EN: while idle, a +1 gust offset toggles
// every 8*RAMP_DIV cycles (clamped to WIND_MAX); absent, wind is the ramp value.
module wind_gen import wind_pkg::*; #(
  parameter int unsigned WIND_W    = 7,
  parameter int unsigned WIND_MAX  = WIND_MAX_DEF,
  parameter int unsigned WIND_INIT = WIND_INIT_DEF,
  parameter int unsigned LFSR_W    = 16,
  parameter logic [31:0] LFSR_SEED = 32'h0000_ACE1,
  parameter int unsigned RAMP_DIV  = 1_000_000
) (
  input  logic      clk,
  input  logic      rst,
  wind_gen_if.slave bus
);

  localparam logic [WIND_W-1:0] MAX_V    = WIND_W'(WIND_MAX);
  localparam logic [WIND_W-1:0] INIT_V   = WIND_W'(WIND_INIT);
  localparam int unsigned       CNT_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_TERM = CNT_W'(RAMP_DIV - 1);
  localparam logic [15:0]       SCALE_M  = 16'(WIND_MAX + 1);

  wind_state_t       state, state_n;
  logic [WIND_W-1:0] cur, cur_n, tgt, tgt_n, scaled, val;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              mirror, mirror_n;
  logic              nt_prev, draw_req, step;
  logic [LFSR_W-1:0] lfsr;
  logic [15:0]       prod;
  logic [WIND_W-1:0] wind_q;
  logic              settled_q;
  logic              lfsr_unused;

  wind_lfsr #(
    .LFSR_W    (LFSR_W),
    .LFSR_SEED (LFSR_SEED[LFSR_W-1:0])
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (step),
    .value (lfsr)
  );

  // Only the top byte feeds the scaler; the low bits just carry the sequence.
  assign lfsr_unused = ^lfsr[LFSR_W-9:0];

  // Top byte * (WIND_MAX+1) / 256 maps 0..255 onto 0..WIND_MAX with no modulo bias step.
  assign prod   = 16'(lfsr[LFSR_W-1 -: 8]) * SCALE_M;
  assign scaled = WIND_W'(prod >> 8);

  assign draw_req = bus.next_turn & ~nt_prev;

  always_comb begin
    state_n  = state;
    cur_n    = cur;
    tgt_n    = tgt;
    cnt_n    = cnt;
    mirror_n = mirror | bus.enter_start_remote;
    step     = 1'b0;
    if (bus.reset_flag) begin
      // Restart wins over mirror pulses and draw requests; LFSR keeps its place.
      state_n  = IDLE;
      cur_n    = INIT_V;
      tgt_n    = INIT_V;
      cnt_n    = '0;
      mirror_n = 1'b0;
    end else begin
      unique case (state)
        IDLE: ;
        DRAW: begin
          tgt_n   = scaled;
          cnt_n   = '0;
          state_n = (scaled == cur) ? IDLE : RAMP;
        end
        RAMP: begin
          if (cur == tgt) begin
            state_n = IDLE;
          end else if (cnt == CNT_TERM) begin
            cnt_n = '0;
            cur_n = (cur < tgt) ? cur + 1'b1 : cur - 1'b1;
            if (cur_n == tgt) state_n = IDLE;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
      // A fresh request overrides the current state; cur is left where it is,
      // so the next ramp continues from the present value without a jump.
      if (draw_req) begin
        step    = 1'b1;
        state_n = DRAW;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cur     <= INIT_V;
      tgt     <= INIT_V;
      cnt     <= '0;
      mirror  <= 1'b0;
      nt_prev <= 1'b0;
    end else begin
      state   <= state_n;
      cur     <= cur_n;
      tgt     <= tgt_n;
      cnt     <= cnt_n;
      mirror  <= mirror_n;
      nt_prev <= bus.next_turn;
    end
  end

`ifdef WIND_GUST_EN
  localparam int unsigned        GUST_DIV  = 8 * RAMP_DIV;
  localparam int unsigned        GCNT_W    = (GUST_DIV > 1) ? $clog2(GUST_DIV) : 1;
  localparam logic [GCNT_W-1:0]  GCNT_TERM = GCNT_W'(GUST_DIV - 1);

  logic [GCNT_W-1:0] gust_cnt;
  logic              gust;

  always_ff @(posedge clk) begin
    if (rst || bus.reset_flag || state != IDLE) begin
      gust_cnt <= '0;
      gust     <= 1'b0;
    end else if (gust_cnt == GCNT_TERM) begin
      gust_cnt <= '0;
      gust     <= ~gust;
    end else begin
      gust_cnt <= gust_cnt + 1'b1;
    end
  end

  assign val = (gust && cur < MAX_V) ? cur + 1'b1 : cur;
`else
  assign val = cur;
`endif

  // Output stage: wind lags the internal value by one register; settled
  // tracks the state being entered so it rises with the final step.
  always_ff @(posedge clk) begin
    if (rst) begin
      wind_q    <= INIT_V;
      settled_q <= 1'b1;
    end else begin
      wind_q    <= mirror ? MAX_V - val : val;
      settled_q <= (state_n == IDLE);
    end
  end

  assign bus.wind         = wind_q;
  assign bus.wind_target  = tgt;
  assign bus.wind_settled = settled_q;

endmodule

// File: tb/tb_wind_gen.sv
// tb_wind_gen: self-checking bench for wind_gen (RAMP_DIV = 4, 16-bit LFSR).
// Expected targets come from a bench-side LFSR/scaler model and are queued
// when a draw is driven, then popped when wind_target becomes valid.
module tb_wind_gen;

  localparam int RDIV = 4;
  localparam int WMAX = 100;
  localparam int WINI = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wind_gen_if #(.WIND_W(7)) bus ();

  wind_gen #(
    .WIND_W    (7),
    .WIND_MAX  (WMAX),
    .WIND_INIT (WINI),
    .LFSR_W    (16),
    .LFSR_SEED (32'h0000_ACE1),
    .RAMP_DIV  (RDIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic nt, esr, rf;
    int   wind, tgt;
    logic settled;
  } vec_t;

  vec_t        tbl [6];
  int          exp_q [$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_lfsr;
  logic        mon_en = 1'b0;
  int          prev_w = 0;
  int          jump_bad = 0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic int scale(input logic [15:0] v);
    return (int'(v[15:8]) * (WMAX + 1)) >> 8;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Wind must never move more than one unit between samples while ramping.
  always @(negedge clk) begin
    if (mon_en && ((int'(bus.wind) - prev_w > 1) || (prev_w - int'(bus.wind) > 1)))
      jump_bad <= jump_bad + 1;
    prev_w <= int'(bus.wind);
  end

  task automatic draw(input string nm);
    m_lfsr = lfsr_next(m_lfsr);
    exp_q.push_back(scale(m_lfsr));
    bus.next_turn = 1'b1;
    @(negedge clk);
    bus.next_turn = 1'b0;
    @(negedge clk);
    check(nm, int'(bus.wind_target), exp_q.pop_front());
  endtask

  task automatic wait_settle(input int budget, output int n);
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (bus.wind_settled) break;
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t1, t2, t3, mid, k, oor, got;
    logic found;

    m_lfsr = 16'hACE1;
    t1 = scale(lfsr_next(m_lfsr));   // ACE1 -> E270, top byte 226 -> 89
    //            nt    esr   rf    wind       tgt   settled
    tbl[0] = '{1'b0, 1'b1, 1'b0, t1,        t1,   1'b1};
    tbl[1] = '{1'b0, 1'b0, 1'b0, WMAX - t1, t1,   1'b1};
    tbl[2] = '{1'b0, 1'b0, 1'b0, WMAX - t1, t1,   1'b1};
    tbl[3] = '{1'b0, 1'b0, 1'b1, WMAX - t1, WINI, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 1'b0, WINI,      WINI, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 1'b1, WINI,      WINI, 1'b1};

    bus.next_turn = 1'b0;
    bus.enter_start_remote = 1'b0;
    bus.reset_flag = 1'b0;

    // Reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_wind", int'(bus.wind), WINI);
    check("rst_target", int'(bus.wind_target), WINI);
    check("rst_settled", int'(bus.wind_settled), 1);
    check("rst_lfsr", int'(dut.u_lfsr.value), 16'hACE1);
    @(negedge clk);
    check("idle_settled", int'(bus.wind_settled), 1);

    // First draw with next_turn held high for the whole ramp (level hold)
    m_lfsr = lfsr_next(m_lfsr);
    exp_q.push_back(scale(m_lfsr));
    bus.next_turn = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check("draw_lfsr_step", int'(dut.u_lfsr.value), int'(m_lfsr));
    check("draw_target_not_yet", int'(bus.wind_target), WINI);
    @(negedge clk);
    check("draw_target", int'(bus.wind_target), exp_q.pop_front());
    check("draw_unsettled", int'(bus.wind_settled), 0);
    wait_settle(600, k);
    check("ramp_cycles", k, (WINI > t1 ? WINI - t1 : t1 - WINI) * RDIV);
    @(negedge clk);
    check("ramp_final_wind", int'(bus.wind), t1);
    check("level_hold_lfsr", int'(dut.u_lfsr.value), int'(m_lfsr));
    check("level_hold_target", int'(bus.wind_target), t1);
    bus.next_turn = 1'b0;
    mon_en = 1'b0;
    @(negedge clk);

    // Mirror latch, reset_flag, and simultaneous reset_flag + enter_start_remote
    foreach (tbl[i]) begin
      bus.next_turn = tbl[i].nt;
      bus.enter_start_remote = tbl[i].esr;
      bus.reset_flag = tbl[i].rf;
      @(negedge clk);
      check($sformatf("tbl%0d_wind", i), int'(bus.wind), tbl[i].wind);
      check($sformatf("tbl%0d_target", i), int'(bus.wind_target), tbl[i].tgt);
      check($sformatf("tbl%0d_settled", i), int'(bus.wind_settled), int'(tbl[i].settled));
    end
    bus.enter_start_remote = 1'b0;
    bus.reset_flag = 1'b0;
    check("rflag_keeps_lfsr", int'(dut.u_lfsr.value), int'(m_lfsr));
    @(negedge clk);

    // Redraw mid-ramp; ending on the raw target also shows mirror stayed clear
    mon_en = 1'b1;
    draw("redraw1_target");
    t2 = scale(m_lfsr);
    mid = (WINI + t2) / 2;
    found = 1'b0;
    for (int c = 0; c < 400 && !found; c++) begin
      @(negedge clk);
      if (int'(bus.wind) == mid) found = 1'b1;
    end
    check("redraw_mid_reached", int'(found), 1);
    draw("redraw2_target");
    t3 = scale(m_lfsr);
    wait_settle(600, k);
    check("redraw_settled", int'(bus.wind_settled), 1);
    @(negedge clk);
    check("redraw_final_wind", int'(bus.wind), t3);
    check("no_wind_jumps", jump_bad, 0);
    mon_en = 1'b0;

    // Sweep of back-to-back draws: every target matches the model and stays in range
    oor = 0;
    for (int i = 0; i < 1000; i++) begin
      m_lfsr = lfsr_next(m_lfsr);
      exp_q.push_back(scale(m_lfsr));
      bus.next_turn = 1'b1;
      @(negedge clk);
      bus.next_turn = 1'b0;
      @(negedge clk);
      got = int'(bus.wind_target);
      if (got > WMAX) oor++;
      check("sweep_target", got, exp_q.pop_front());
    end
    check("sweep_out_of_range", oor, 0);
    check("sweep_lfsr", int'(dut.u_lfsr.value), int'(m_lfsr));
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
